// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage definitions: Funct3 size/sign codes, responder FSM states,
// and helpers classifying access size and alignment.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Codes 011/110/111 fall into the word class.
    function automatic logic is_byte(logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    function automatic logic is_half(logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    function automatic logic misaligned(logic [2:0] f3, logic [1:0] lo);
        if (is_half(f3)) return lo[0];
        if (is_byte(f3)) return 1'b0;
        return lo != 2'b00;
    endfunction

    function automatic logic [1:0] align_down(logic [2:0] f3, logic [1:0] lo);
        if (is_half(f3)) return {lo[1], 1'b0};
        if (is_byte(f3)) return lo;
        return 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request bus: the pipeline (master) drives the request,
// the data-memory responder (slave) returns load data, Stall and MisalignErr.
interface data_mem_responder_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [2:0]  Funct3;
    logic [31:0] RD;
    logic        Stall;
    logic        MisalignErr;

    modport master (output A, WD, WE, RE, Funct3, input RD, Stall, MisalignErr);
    modport slave  (input A, WD, WE, RE, Funct3, output RD, Stall, MisalignErr);
endinterface

// File: rtl/data_mem_responder_align.sv
// Combinational lane logic: byte enables and replicated store word for stores,
// lane select plus sign/zero extension for loads.
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rd_word[{addr, 3'b000} +: 8];
        h       = addr[1] ? rd_word[31:16] : rd_word[15:0];
        byte_en = 4'b0000;
        st_word = st_data;
        ld_data = rd_word;
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << addr;
                st_word = {4{st_data[7:0]}};
            end
            F3_H: begin
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
            end
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        case (funct3)
            F3_B:    ld_data = {{24{b[7]}}, b};
            F3_BU:   ld_data = {24'b0, b};
            F3_H:    ld_data = {{16{h[15]}}, h};
            F3_HU:   ld_data = {16'b0, h};
            default: ld_data = rd_word;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one access at a time with LATENCY stall cycles, byte-enabled stores.
// Define MISALIGN_TRAP_EN to flag/suppress misaligned accesses instead of aligning them down.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW+1:0]   a_q, a_d;
    logic [31:0]     wd_q, wd_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     rd_q, rd_d;
    logic            merr_q, merr_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req, live, fire, mis, mem_we;
    logic [IW+1:0]   cur_a;
    logic [31:0]     cur_wd;
    logic            cur_we;
    logic [2:0]      cur_f3;
    logic [1:0]      lo;
    logic [IW-1:0]   idx;
    logic [3:0]      be;
    logic [31:0]     st_word, ld_data;

    // The accepting IDLE cycle is the first of the LATENCY stall cycles, so the access
    // can fire in that cycle (LATENCY==1) and must then use the live request fields.
    assign req    = bus.WE | bus.RE;
    assign live   = (state_q == S_IDLE);
    assign cur_a  = live ? bus.A[IW+1:0] : a_q;
    assign cur_wd = live ? bus.WD        : wd_q;
    assign cur_we = live ? bus.WE        : we_q;
    assign cur_f3 = live ? bus.Funct3    : f3_q;
    assign fire   = (LATENCY == 1) ? (live && req)
                                   : (state_q == S_BUSY && cnt_q == CW'(1));

`ifdef MISALIGN_TRAP_EN
    assign mis = misaligned(cur_f3, cur_a[1:0]);
    assign lo  = cur_a[1:0];
`else
    assign mis = 1'b0;
    assign lo  = align_down(cur_f3, cur_a[1:0]);
`endif

    assign idx = cur_a[IW+1:2];

    load_store_align u_align (
        .addr    (lo),
        .funct3  (cur_f3),
        .st_data (cur_wd),
        .rd_word (mem[idx]),
        .byte_en (be),
        .st_word (st_word),
        .ld_data (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        wd_d    = wd_q;
        we_d    = we_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        merr_d  = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                a_d     = bus.A[IW+1:0];
                wd_d    = bus.WD;
                we_d    = bus.WE;
                f3_d    = bus.Funct3;
                cnt_d   = CNT_INIT;
                state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
            end
            S_BUSY: if (cnt_q != CW'(1)) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d   = '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fire) begin
            merr_d = mis;
            if (mis)          rd_d = '0;
            else if (!cur_we) rd_d = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            merr_q  <= merr_d;
        end
    end

    // Contents survive reset; a store firing in a reset cycle is dropped.
    assign mem_we = fire && cur_we && !mis && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
            end
        end
    end

    assign bus.RD          = rd_q;
    assign bus.MisalignErr = merr_q;
    assign bus.Stall       = (live && req) || (state_q == S_BUSY);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against a byte-array memory model;
// follows MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int NBYTES      = DEPTH_WORDS * 4;

    typedef struct {
        logic [31:0] rd;
        logic        merr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [7:0]  mem_b [NBYTES];
    logic [31:0] model_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, access width from the size code.
    task automatic model_step(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output exp_t e);
        int unsigned n, base;
        logic        trap;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        trap = (a % n) != 0;
`else
        trap = 1'b0;
`endif
        base = (a - (a % n)) % NBYTES;
        e.merr = trap;
        if (trap) begin
            model_rd = '0;
        end else if (we) begin
            if (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                for (int i = 0; i < int'(n); i++) mem_b[base + i] = 8'(wd >> (8 * i));
        end else begin
            v = '0;
            for (int i = 0; i < int'(n); i++) v = v | (32'(mem_b[base + i]) << (8 * i));
            if (n < 4 && !f3[2] && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            model_rd = v;
        end
        e.rd = model_rd;
    endtask

    // Called just after a rising edge with the responder idle; returns likewise.
    task automatic access(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        bit   done;
        model_step(we, f3, a, wd, e);
        exp_q.push_back(e);
        bus.A = a; bus.WD = wd; bus.WE = we; bus.RE = re; bus.Funct3 = f3;
        n = 0; done = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (!bus.Stall) done = 1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL access_timeout: A=%h still stalled after %0d cycles", a, n);
        end
        @(posedge clk); #1;
        bus.WE = 1'b0; bus.RE = 1'b0;
    endtask

    task automatic idle(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: DONE is the first non-stalled cycle after stall; RD/MisalignErr held otherwise.
    initial begin
        bit   prev_stall = 0;
        int   run = 0;
        logic [31:0] last_rd = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; run = 0; last_rd = '0;
            end else begin
                if (bus.Stall) begin
                    run++;
                    chk("rd_hold_busy", bus.RD, last_rd);
                end else if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: RD=%h with empty scoreboard", bus.RD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd", bus.RD, e.rd);
                        chk("misalign_done", 32'(bus.MisalignErr), 32'(e.merr));
                        chk("stall_cycles", 32'(run), 32'(LATENCY));
                        last_rd = e.rd;
                    end
                    run = 0;
                end else begin
                    chk("rd_hold_idle", bus.RD, last_rd);
                    chk("misalign_idle", 32'(bus.MisalignErr), 32'd0);
                end
                prev_stall = bus.Stall;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, t;
        int kind;
        bus.A = '0; bus.WD = '0; bus.WE = 1'b0; bus.RE = 1'b0; bus.Funct3 = F3_W;
        @(posedge clk);
        @(negedge clk);
        chk("reset_rd", bus.RD, 32'd0);
        chk("reset_stall", 32'(bus.Stall), 32'd0);
        chk("reset_misalign", 32'(bus.MisalignErr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill every word so all later loads have defined contents.
        for (int w = 0; w < DEPTH_WORDS; w++) access(1'b1, 1'b0, F3_W, 32'(w * 4), $urandom);

        access(1, 0, F3_W,  32'h10, 32'hDEADBEEF);
        access(0, 1, F3_W,  32'h10, 32'h0);
        access(1, 0, F3_B,  32'h11, 32'h80);
        access(0, 1, F3_B,  32'h11, 32'h0);
        access(0, 1, F3_BU, 32'h11, 32'h0);
        access(0, 1, F3_W,  32'h10, 32'h0);
        access(1, 0, F3_H,  32'h12, 32'h1234);
        access(0, 1, F3_HU, 32'h12, 32'h0);
        access(0, 1, F3_W,  32'h10, 32'h0);
        access(1, 1, F3_W,  32'h20, 32'h5);
        access(0, 1, F3_W,  32'h20, 32'h0);
        access(1, 0, F3_W,  32'h400, 32'h7);
        access(0, 1, F3_W,  32'h0, 32'h0);
        access(0, 1, F3_W,  32'h13, 32'h0);
        idle(2);

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 3);
            t = $urandom;
            a = (t & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            access(kind == 1 || kind == 2, kind != 1, 3'($urandom_range(0, 7)), a, $urandom);
            idle($urandom_range(0, 2));
        end

        // Reset during the BUSY cycle of a store: store discarded, outputs cleared.
        bus.A = 32'h30; bus.WD = 32'h9; bus.WE = 1'b1; bus.RE = 1'b0; bus.Funct3 = F3_W;
        @(posedge clk); #1;
        rst = 1'b1; bus.WE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd = '0;
        @(negedge clk);
        chk("rst_mid_stall", 32'(bus.Stall), 32'd0);
        chk("rst_mid_rd", bus.RD, 32'd0);
        @(posedge clk); #1;
        access(0, 1, F3_W, 32'h30, 32'h0);
        access(0, 1, F3_H, 32'h33, 32'h0);

        idle(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
